// File: rtl/input_pixel_encoder.sv
// input_pixel_encoder
//   Thresholds a raster-ordered grayscale pixel stream and queues the index of
//   every active pixel (pixelIn >= THRESHOLD) for the Layer 1 controller.
//   Loading and serving alternate: an image is loaded (LOAD), then its queue
//   is drained (SERVE), then the next image may be loaded.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   pixelIn      in   current pixel value
//   pixelValid   in   pixelIn is valid this cycle
//   pixelReady   out  block accepts a pixel this cycle (LOAD)
//   inputsReady  out  image fully loaded, queue is being served (SERVE)
//   queueEmpty   out  no unread index available
//   dequeue      in   pop the head index
//   queueOut     out  head index, valid while queueEmpty == 0
//   activeCount  out  number of active pixels in the latest loaded image
//   fsm_state    out  current FSM state (0 = LOAD, 1 = SERVE), debug view
//
// Handshakes: a pixel transfers on a rising edge where pixelValid &&
// pixelReady; an index is popped on a rising edge where dequeue && !queueEmpty.
// Neither input has a combinational path to any output.

module input_pixel_encoder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int NUM_PIXELS  = 784,
  parameter int INDEX_WIDTH = 10,
  parameter int THRESHOLD   = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] pixelIn,
  input  logic                   pixelValid,
  output logic                   pixelReady,
  output logic                   inputsReady,
  output logic                   queueEmpty,
  input  logic                   dequeue,
  output logic [INDEX_WIDTH-1:0] queueOut,
  output logic [INDEX_WIDTH-1:0] activeCount,
  output logic                   fsm_state
);

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_PIXELS - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE      = INDEX_WIDTH'(1);
  localparam logic [PIXEL_WIDTH-1:0] THRESH   = PIXEL_WIDTH'(THRESHOLD);

  state_t state;
  state_t state_next;

  logic [INDEX_WIDTH-1:0] wr_ptr;
  logic [INDEX_WIDTH-1:0] rd_ptr;
  logic [INDEX_WIDTH-1:0] pix_cnt;
  logic [INDEX_WIDTH-1:0] active_cnt;
  logic [INDEX_WIDTH-1:0] head;
  logic [INDEX_WIDTH-1:0] rd_next;

  logic [INDEX_WIDTH-1:0] mem [0:NUM_PIXELS-1];

  logic accept;
  logic pixel_active;
  logic last_pixel;
  logic empty;
  logic pop;

  assign accept       = (state == LOAD) && pixelValid;
  assign pixel_active = (pixelIn >= THRESH);
  assign last_pixel   = (pix_cnt == LAST_IDX);
  // LOAD always looks empty to the consumer; SERVE is empty once every
  // latched index has been read.
  assign empty        = (state == SERVE) ? (rd_ptr == active_cnt) : 1'b1;
  assign pop          = (state == SERVE) && dequeue && !empty;
  assign rd_next      = rd_ptr + ONE;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (accept && last_pixel) begin
          state_next = SERVE;
        end
      end
      SERVE: begin
        if (empty) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pix_cnt    <= '0;
      active_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (pixel_active) begin
              wr_ptr <= wr_ptr + ONE;
            end
            if (last_pixel) begin
              pix_cnt    <= '0;
              rd_ptr     <= '0;
              // Include the final pixel's own write in the count.
              active_cnt <= wr_ptr + (pixel_active ? ONE : '0);
            end else begin
              pix_cnt <= pix_cnt + ONE;
            end
          end
        end
        SERVE: begin
          if (pop) begin
            rd_ptr <= rd_next;
          end
          if (empty) begin
            wr_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Index storage; written only in LOAD, read only in SERVE.
  always_ff @(posedge clk) begin
    if (accept && pixel_active) begin
      mem[wr_ptr] <= pix_cnt;
    end
  end

  // Registered head-of-queue. Captures the first index as it is written so
  // mem[0] is presented in the first SERVE cycle, then prefetches the next
  // entry on each pop. After the last pop it holds its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
    end else if (accept && pixel_active && (wr_ptr == '0)) begin
      head <= pix_cnt;
    end else if (pop && (rd_next != active_cnt)) begin
      head <= mem[rd_next];
    end
  end

  assign pixelReady  = (state == LOAD);
  assign inputsReady = (state == SERVE);
  assign queueEmpty  = empty;
  assign queueOut    = head;
  assign activeCount = active_cnt;
  assign fsm_state   = state;

endmodule
